fft8_frame_ctrl: RTL and testbench

FFT8_FRAME_CTRL -- requirements
Module: fft8_frame_ctrl

---
 rtl/fft8_frame_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fft8_frame_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_ctrl.sv
// Frame controller for an external 8-point FFT core: gathers 8 input samples,
// presents them to the core for CORE_LAT clocks, then streams the 8 result bins.
`timescale 1ns/1ps

module fft8_frame_ctrl #(
    parameter int CORE_LAT = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [17:0]  in_re,
    input  logic [17:0]  in_im,
    output logic [143:0] core_xr,
    output logic [143:0] core_xi,
    input  logic [287:0] core_or,
    input  logic [287:0] core_oi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [35:0]  out_re,
    output logic [35:0]  out_im,
    output logic [2:0]   out_idx,
    output logic         out_last,
    output logic         busy,
    output logic [15:0]  frame_cnt
);

    localparam logic [3:0] LAT = 4'(CORE_LAT);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [2:0]   ld_idx_reg;
    logic [3:0]   run_cnt_reg;
    logic [2:0]   out_idx_reg;
    logic [15:0]  frame_cnt_reg;
    logic [143:0] core_xr_reg;
    logic [143:0] core_xi_reg;

    logic [17:0]  shadow_re_reg [0:6];
    logic [17:0]  shadow_im_reg [0:6];
    logic [35:0]  bin_re_reg    [0:7];
    logic [35:0]  bin_im_reg    [0:7];

    logic [143:0] frame_re;
    logic [143:0] frame_im;

    logic accept;
    logic last_accept;
    logic capture;
    logic out_hs;
    logic last_hs;

    assign accept      = in_valid & in_ready;
    assign last_accept = accept & (ld_idx_reg == 3'd7);
    assign capture     = (state_reg == ST_RUN) & (run_cnt_reg == LAT);
    assign out_hs      = out_valid & out_ready;
    assign last_hs     = out_hs & out_last;

    // The frame handed to the core is the 7 shadow slots plus the sample on the wire.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_re_reg[gi] <= '0;
                    shadow_im_reg[gi] <= '0;
                end else if (accept && (ld_idx_reg == 3'(gi))) begin
                    shadow_re_reg[gi] <= in_re;
                    shadow_im_reg[gi] <= in_im;
                end
            end
            assign frame_re[18*gi +: 18] = shadow_re_reg[gi];
            assign frame_im[18*gi +: 18] = shadow_im_reg[gi];
        end
    endgenerate

    assign frame_re[143:126] = in_re;
    assign frame_im[143:126] = in_im;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_bins
            always_ff @(posedge clk) begin
                if (rst) begin
                    bin_re_reg[gi] <= '0;
                    bin_im_reg[gi] <= '0;
                end else if (capture) begin
                    bin_re_reg[gi] <= core_or[36*gi +: 36];
                    bin_im_reg[gi] <= core_oi[36*gi +: 36];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD:   if (last_accept) state_next = ST_RUN;
            ST_RUN:    if (capture)     state_next = ST_UNLOAD;
            ST_UNLOAD: if (last_hs)     state_next = ST_LOAD;
            default:                    state_next = ST_LOAD;
        endcase
    end

    // in_ready is gated by rst directly so no sample can be offered during reset.
    always_comb begin
        in_ready  = (state_reg == ST_LOAD) & ~rst;
        out_valid = (state_reg == ST_UNLOAD);
        out_last  = (state_reg == ST_UNLOAD) & (out_idx_reg == 3'd7);
        busy      = (state_reg != ST_LOAD);
        out_re    = bin_re_reg[out_idx_reg];
        out_im    = bin_im_reg[out_idx_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_idx_reg    <= '0;
            run_cnt_reg   <= '0;
            out_idx_reg   <= '0;
            frame_cnt_reg <= '0;
            core_xr_reg   <= '0;
            core_xi_reg   <= '0;
        end else begin
            if (last_accept) begin
                ld_idx_reg  <= '0;
                run_cnt_reg <= '0;
                core_xr_reg <= frame_re;
                core_xi_reg <= frame_im;
            end else begin
                if (accept) begin
                    ld_idx_reg <= ld_idx_reg + 3'd1;
                end
                if (state_reg == ST_RUN) begin
                    run_cnt_reg <= run_cnt_reg + 4'd1;
                end
            end

            if (capture) begin
                out_idx_reg <= '0;
            end else if (last_hs) begin
                out_idx_reg   <= '0;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end else if (out_hs) begin
                out_idx_reg <= out_idx_reg + 3'd1;
            end
        end
    end

    assign core_xr   = core_xr_reg;
    assign core_xi   = core_xi_reg;
    assign out_idx   = out_idx_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl with a behavioural 8-point DFT core
// (twiddles scaled by 1000) pipelined CORE_LAT clocks deep.
`timescale 1ns/1ps

module tb_fft8_frame_ctrl;

    localparam int CORE_LAT = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [17:0]  in_re = '0;
    logic [17:0]  in_im = '0;
    logic [143:0] core_xr;
    logic [143:0] core_xi;
    logic [287:0] core_or;
    logic [287:0] core_oi;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [35:0]  out_re;
    logic [35:0]  out_im;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic [15:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [35:0] got_re   [8];
    logic [35:0] got_im   [8];
    logic [2:0]  got_idx  [8];
    logic        got_last [8];

    logic [15:0]  rdy_pat = 16'b0110_1001_1101_0010;
    logic [143:0] imp_vec = 144'd1;
    logic [143:0] dc_vec  = {8{18'd1}};

    always #5 clk = ~clk;

    fft8_frame_ctrl #(.CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .core_xr(core_xr), .core_xi(core_xi), .core_or(core_or), .core_oi(core_oi),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    function automatic longint cw(input int m);
        case (m % 8)
            0: cw = 1000;  1: cw = 707;   2: cw = 0;     3: cw = -707;
            4: cw = -1000; 5: cw = -707;  6: cw = 0;     default: cw = 707;
        endcase
    endfunction

    function automatic longint sw(input int m);
        case (m % 8)
            0: sw = 0;     1: sw = 707;   2: sw = 1000;  3: sw = 707;
            4: sw = 0;     5: sw = -707;  6: sw = -1000; default: sw = -707;
        endcase
    endfunction

    function automatic logic [287:0] dft(input logic [143:0] xr, input logic [143:0] xi,
                                         input bit want_im);
        logic [287:0] res;
        longint ar, ai, vr, vi;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            ar = 0;
            ai = 0;
            for (int n = 0; n < 8; n++) begin
                vr = longint'($signed(xr[18*n +: 18]));
                vi = longint'($signed(xi[18*n +: 18]));
                ar = ar + vr * cw(n * k) + vi * sw(n * k);
                ai = ai + vi * cw(n * k) - vr * sw(n * k);
            end
            res[36*k +: 36] = want_im ? ai[35:0] : ar[35:0];
        end
        return res;
    endfunction

    logic [287:0] pipe_re [CORE_LAT];
    logic [287:0] pipe_im [CORE_LAT];

    always @(posedge clk) begin
        pipe_re[0] <= dft(core_xr, core_xi, 1'b0);
        pipe_im[0] <= dft(core_xr, core_xi, 1'b1);
        for (int i = 1; i < CORE_LAT; i++) begin
            pipe_re[i] <= pipe_re[i-1];
            pipe_im[i] <= pipe_im[i-1];
        end
    end

    assign core_or = pipe_re[CORE_LAT-1];
    assign core_oi = pipe_im[CORE_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed one frame with in_valid held high; gap inserts an idle cycle after sample 3.
    task automatic load_frame(input logic [143:0] fr, input logic [143:0] fi, input bit gap);
        for (int n = 0; n < 8; n++) begin
            if (gap && n == 4) begin
                in_valid = 1'b0;
                in_re = 18'h3ffff;
                tick();
            end
            in_valid = 1'b1;
            in_re = fr[18*n +: 18];
            in_im = fi[18*n +: 18];
            tick();
        end
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
    endtask

    // Collect 8 bins; bp toggles out_ready, poke pulses in_valid while busy.
    task automatic unload_frame(input bit bp, input bit poke,
                                output int lat, output int hs, output int stall_bad);
        int cyc;
        bit r, prev_stall;
        logic [35:0] p_re, p_im;
        logic [2:0] p_idx;
        logic p_last;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (poke) begin
                in_valid = (lat % 2 == 0);
                in_re = 18'h155;
            end
            tick();
            lat++;
        end
        hs = 0; stall_bad = 0; cyc = 0; prev_stall = 0;
        p_re = '0; p_im = '0; p_idx = '0; p_last = 0;
        while (hs < 8 && cyc < 200) begin
            if (prev_stall && (out_re !== p_re || out_im !== p_im || out_idx !== p_idx ||
                               out_last !== p_last || out_valid !== 1'b1))
                stall_bad++;
            r = bp ? rdy_pat[cyc % 16] : 1'b1;
            out_ready = r;
            if (poke) begin
                in_valid = !(r && out_last) && (cyc % 3 == 0);
                in_re = 18'h155;
            end
            if (out_valid && r) begin
                got_re[hs] = out_re;
                got_im[hs] = out_im;
                got_idx[hs] = out_idx;
                got_last[hs] = out_last;
                $display("bin %0d re %0d im %0d last %0d", out_idx, $signed(out_re),
                         $signed(out_im), out_last);
                hs++;
            end
            prev_stall = out_valid && !r;
            p_re = out_re; p_im = out_im; p_idx = out_idx; p_last = out_last;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0d want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0d want 0", out_last); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (core_xr !== 144'd0 || core_xi !== 144'd0) begin errors++; $display("FAIL reset_core_x got %h want 0", core_xr); end
        checks++; if (out_re !== 36'd0 || out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_re got %0d want 0", out_re); end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0d want 1", in_ready); end
        $display("reset done");
    endtask

    task automatic test_impulse();
        int lat, hs, sb;
        load_frame(imp_vec, 144'd0, 1'b0);
        checks++; if (core_xr !== 144'd1 || core_xi !== 144'd0) begin errors++; $display("FAIL imp_core_xr got %h want 1", core_xr); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL imp_run_flags got busy %0d rdy %0d want 1 0", busy, in_ready); end
        unload_frame(1'b0, 1'b0, lat, hs, sb);
        checks++; if (lat !== 6) begin errors++; $display("FAIL imp_latency got %0d want 6", lat); end
        checks++; if (hs !== 8) begin errors++; $display("FAIL imp_handshakes got %0d want 8", hs); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (got_re[i] !== 36'd1000 || got_im[i] !== 36'd0) begin errors++; $display("FAIL imp_bin%0d got %0d,%0d want 1000,0", i, $signed(got_re[i]), $signed(got_im[i])); end
            checks++; if (got_idx[i] !== 3'(i)) begin errors++; $display("FAIL imp_idx%0d got %0d want %0d", i, got_idx[i], i); end
            checks++; if (got_last[i] !== (i == 7)) begin errors++; $display("FAIL imp_last%0d got %0d want %0d", i, got_last[i], (i == 7)); end
        end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL imp_end_flags got v %0d r %0d b %0d want 0 1 0", out_valid, in_ready, busy); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL imp_frame_cnt got %0d want 1", frame_cnt); end
        $display("impulse frame done");
    endtask

    task automatic test_dc();
        int lat, hs, sb;
        load_frame(dc_vec, 144'd0, 1'b1);
        checks++; if (core_xr !== dc_vec) begin errors++; $display("FAIL dc_core_xr got %h want %h", core_xr, dc_vec); end
        unload_frame(1'b0, 1'b0, lat, hs, sb);
        checks++; if (lat !== 6 || hs !== 8) begin errors++; $display("FAIL dc_timing got lat %0d hs %0d want 6 8", lat, hs); end
        checks++; if (got_re[0] !== 36'd8000 || got_im[0] !== 36'd0) begin errors++; $display("FAIL dc_bin0 got %0d,%0d want 8000,0", $signed(got_re[0]), $signed(got_im[0])); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (got_re[i] !== 36'd0 || got_im[i] !== 36'd0) begin errors++; $display("FAIL dc_bin%0d got %0d,%0d want 0,0", i, $signed(got_re[i]), $signed(got_im[i])); end
        end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL dc_frame_cnt got %0d want 2", frame_cnt); end
        $display("dc frame done");
    endtask

    task automatic test_backpressure();
        int lat, hs, sb;
        load_frame(imp_vec, 144'd0, 1'b0);
        unload_frame(1'b1, 1'b1, lat, hs, sb);
        checks++; if (hs !== 8) begin errors++; $display("FAIL bp_handshakes got %0d want 8", hs); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d violations want 0", sb); end
        checks++; if (core_xr !== 144'd1 || core_xi !== 144'd0) begin errors++; $display("FAIL bp_core_xr got %h want 1", core_xr); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (got_re[i] !== 36'd1000 || got_idx[i] !== 3'(i)) begin errors++; $display("FAIL bp_bin%0d got %0d idx %0d want 1000 idx %0d", i, $signed(got_re[i]), got_idx[i], i); end
        end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL bp_frame_cnt got %0d want 3", frame_cnt); end
        // Any sample wrongly taken while busy would shift this frame's content.
        load_frame(dc_vec, 144'd0, 1'b0);
        checks++; if (core_xr !== dc_vec) begin errors++; $display("FAIL bp_next_frame got %h want %h", core_xr, dc_vec); end
        unload_frame(1'b0, 1'b0, lat, hs, sb);
        checks++; if (got_re[0] !== 36'd8000 || hs !== 8) begin errors++; $display("FAIL bp_next_bin0 got %0d hs %0d want 8000 8", $signed(got_re[0]), hs); end
        $display("backpressure frames done");
    endtask

    task automatic test_reset_mid();
        int lat, hs, sb;
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            in_re = 18'd5;
            in_im = 18'd3;
            tick();
        end
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %0d want 0", in_ready); end
        rst = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        checks++; if (frame_cnt !== 16'd0 || core_xr !== 144'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_cleared got fc %0d busy %0d want 0 0", frame_cnt, busy); end
        load_frame(dc_vec, 144'd0, 1'b0);
        checks++; if (core_xr !== dc_vec || core_xi !== 144'd0) begin errors++; $display("FAIL rstmid_core_xr got %h want %h", core_xr, dc_vec); end
        unload_frame(1'b0, 1'b0, lat, hs, sb);
        checks++; if (lat !== 6 || hs !== 8) begin errors++; $display("FAIL rstmid_timing got lat %0d hs %0d want 6 8", lat, hs); end
        checks++; if (got_re[0] !== 36'd8000 || got_re[1] !== 36'd0 || got_re[7] !== 36'd0) begin errors++; $display("FAIL rstmid_bins got %0d %0d %0d want 8000 0 0", $signed(got_re[0]), $signed(got_re[1]), $signed(got_re[7])); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_frame_cnt got %0d want 1", frame_cnt); end
        $display("reset during load done");
    endtask

    task automatic test_reset_unload();
        int wait_cyc, seen;
        load_frame(imp_vec, 144'd0, 1'b0);
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 40) begin tick(); wait_cyc++; end
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) seen++;
            tick();
        end
        out_ready = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstunl_out_valid got %0d cycles want 0", seen); end
        checks++; if (frame_cnt !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstunl_state got fc %0d rdy %0d want 0 1", frame_cnt, in_ready); end
        $display("reset during unload done");
    endtask

    task automatic test_wrap();
        int lat, hs, sb;
        force dut.frame_cnt_reg = 16'hFFFF;
        #1;
        release dut.frame_cnt_reg;
        load_frame(imp_vec, 144'd0, 1'b0);
        unload_frame(1'b0, 1'b0, lat, hs, sb);
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_frame_cnt got %h want 0000", frame_cnt); end
        checks++; if (hs !== 8 || got_re[3] !== 36'd1000) begin errors++; $display("FAIL wrap_frame got hs %0d bin3 %0d want 8 1000", hs, $signed(got_re[3])); end
        $display("frame counter wrap done");
    endtask

    task automatic test_back_to_back();
        int acc [16];
        int na, ov;
        na = 0;
        ov = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            in_re = 18'(c);
            if (in_ready && na < 16) begin acc[na] = c; na++; end
            if (out_valid && c < 22) ov++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (na < 9) begin errors++; $display("FAIL b2b_accepts got %0d want >= 9", na); end
        else begin
            checks++; if (acc[8] - acc[0] !== 22) begin errors++; $display("FAIL b2b_period got %0d want 22", acc[8] - acc[0]); end
            checks++; if (acc[7] - acc[0] !== 7) begin errors++; $display("FAIL b2b_load_span got %0d want 7", acc[7] - acc[0]); end
        end
        checks++; if (ov !== 8) begin errors++; $display("FAIL b2b_out_cycles got %0d want 8", ov); end
        $display("back-to-back frames done");
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_backpressure();
        test_reset_mid();
        test_reset_unload();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
